// File: rtl/badpixel_lut_writer_pkg.sv
// Shared DPC definitions: LUT word layout, raster-order key compare and writer FSM states.
package badpixel_lut_writer_pkg;

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  // LUT word: x in [31:16], y in [15:0]
  function automatic logic [31:0] pack_lut_word(input logic [15:0] x, input logic [15:0] y);
    return {x, y};
  endfunction

  function automatic logic [15:0] lut_x(input logic [31:0] w);
    return w[31:16];
  endfunction

  function automatic logic [15:0] lut_y(input logic [31:0] w);
    return w[15:0];
  endfunction

  // Raster order is row-major, so the y field is the more significant part of the key.
  function automatic logic raster_gt(input logic [31:0] a, input logic [31:0] b);
    return {lut_y(a), lut_x(a)} > {lut_y(b), lut_x(b)};
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Rising-edge detector on the frame_start level. The history register resets to 1
// so that a frame_start held high through reset does not look like a new frame.
module frame_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  output logic boundary
);

  logic fs_q;

  always_ff @(posedge clk) begin
    if (rst) fs_q <= 1'b1;
    else     fs_q <= frame_start;
  end

  assign boundary = frame_start && !fs_q;

endmodule

// File: rtl/badpixel_lut_writer.sv
// Packs flagged pixel coordinates into a ping-pong LUT and publishes the finished
// bank plus its entry count to the checker at every frame boundary.
module badpixel_lut_writer
  import badpixel_lut_writer_pkg::*;
#(
  parameter int WIDTH_BITS    = 10,
  parameter int HEIGHT_BITS   = 10,
  parameter int BAD_POINT_NUM = 128,
  parameter int BAD_POINT_BIT = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     pix_valid,
  input  logic [WIDTH_BITS-1:0]    current_x,
  input  logic [HEIGHT_BITS-1:0]   current_y,
  input  logic                     bad_flag,
  input  logic                     freeze,
  output logic                     wen_lut,
  output logic [BAD_POINT_BIT:0]   waddr_lut,
  output logic [31:0]              wdata_lut,
  output logic                     active_bank,
  output logic [BAD_POINT_BIT:0]   bad_point_num,
  output logic                     frame_overflow,
  output logic                     order_err
);

  localparam int CW = BAD_POINT_BIT + 1;

  state_t          state, state_nx;
  logic            boundary;
  logic [CW-1:0]   count;
  logic            ov_acc, oe_acc, last_vld;
  logic [31:0]     last_word, pix_word;
  logic            wb, accept, dup, order_ok, full;

  frame_edge_detect u_edge (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .boundary    (boundary)
  );

  assign wb       = ~active_bank;
  assign pix_word = pack_lut_word(16'(current_x), 16'(current_y));
  assign accept   = (state == COLLECT) && pix_valid && bad_flag && !boundary;
  assign dup      = last_vld && (pix_word == last_word);
  assign order_ok = !last_vld || raster_gt(pix_word, last_word);
  assign full     = count >= CW'(BAD_POINT_NUM);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (boundary) state_nx = COLLECT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_lut        <= 1'b0;
      waddr_lut      <= '0;
      wdata_lut      <= '0;
      active_bank    <= 1'b0;
      bad_point_num  <= '0;
      frame_overflow <= 1'b0;
      order_err      <= 1'b0;
      count          <= '0;
      ov_acc         <= 1'b0;
      oe_acc         <= 1'b0;
      last_vld       <= 1'b0;
      last_word      <= '0;
    end else begin
      wen_lut <= 1'b0;
      if (boundary) begin
        // IDLE only opens the first frame; there is nothing finished to publish yet
        if (state == COLLECT && !freeze) begin
          active_bank    <= wb;
          bad_point_num  <= count;
          frame_overflow <= ov_acc;
          order_err      <= oe_acc;
        end
        count    <= '0;
        ov_acc   <= 1'b0;
        oe_acc   <= 1'b0;
        last_vld <= 1'b0;
      end else if (accept && !dup) begin
        // a duplicate would also fail the strict order test, so it is filtered first
        if (!order_ok)  oe_acc <= 1'b1;
        else if (full)  ov_acc <= 1'b1;
        else begin
          wen_lut   <= 1'b1;
          waddr_lut <= {wb, count[BAD_POINT_BIT-1:0]};
          wdata_lut <= pix_word;
          count     <= count + CW'(1);
          last_word <= pix_word;
          last_vld  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/badpixel_lut_writer.md
# badpixel_lut_writer

Autonomous producer of the bad-pixel coordinate LUT. Consumes per-pixel detection flags from the dynamic detector in raster order, packs each flagged coordinate into a 32-bit LUT word, and writes it into a ping-pong (two-bank) LUT. At every frame boundary it publishes the finished bank and its entry count to the bad-pixel checker. It sits between the detector and the LUT BRAM write port, in the same clock domain as the pixel pipeline.

## Interface
- WIDTH_BITS, 10, x coordinate width
- HEIGHT_BITS, 10, y coordinate width
- BAD_POINT_NUM, 128, entries per bank
- BAD_POINT_BIT, 7, log2(BAD_POINT_NUM)

Ports. Single clock `clk`; reset is synchronous and active-high (`rst`).
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  level; its rising edge marks a frame boundary
- pix_valid  in  1  current_x/current_y/bad_flag valid this cycle
- current_x  in  WIDTH_BITS  pixel column
- current_y  in  HEIGHT_BITS  pixel row
- bad_flag  in  1  detector verdict for this pixel
- freeze  in  1  host hold; sampled at the boundary
- wen_lut  out  1  LUT write strobe
- waddr_lut  out  BAD_POINT_BIT+1  {bank, index}
- wdata_lut  out  32  {x zero-extended to 16 bits, y zero-extended to 16 bits}
- active_bank  out  1  bank the checker must read
- bad_point_num  out  BAD_POINT_BIT+1  entry count of active_bank
- frame_overflow  out  1  last committed frame dropped entries
- order_err  out  1  last committed frame saw non-raster-order input

## Operation
- Boundary detection: `fs_q <= frame_start`; a boundary is `frame_start && !fs_q`. Reset loads `fs_q = 1`, so a frame_start held high through reset produces no boundary.
- FSM states:
  - IDLE (reset state): ignores pixels and leaves the outputs untouched. A boundary moves it to COLLECT with count=0 and no commit.
  - COLLECT: on a boundary, performs a commit (or discard) and stays in COLLECT.
- Write bank `wb` is always `~active_bank`.
- Accept condition, in COLLECT: `pix_valid && bad_flag && !boundary`. An accepted pixel is written when all three hold:
  - count < BAD_POINT_NUM;
  - the coordinate differs from the last written coordinate (dedupe);
  - the coordinate is strictly greater in raster order, compared as {y,x}, than the last written one. The first entry of a frame always passes.
- A failing order check drops the pixel and sets sticky `oe_acc`. A full table drops the pixel and sets sticky `ov_acc`. A duplicate is dropped silently.
- Commit on a boundary with freeze=0:
  - active_bank <= wb;
  - bad_point_num <= count;
  - frame_overflow <= ov_acc; order_err <= oe_acc;
  - count, ov_acc and oe_acc clear; last-coordinate valid clears.
- Boundary with freeze=1: no swap and the published outputs hold. count and the flags clear, and the next frame rewrites the same inactive bank.
- A pixel arriving in the same cycle as a boundary is dropped, because the boundary owns that cycle.

## Timing
- Write latency is 1 cycle. wen_lut, waddr_lut and wdata_lut are registered and asserted the cycle after an accepted pixel.
- At most one write per cycle. wen_lut is a single-cycle pulse per entry.
- Commit outputs update 1 cycle after the boundary cycle. Every write of the old frame has already been issued by then, because the last write is registered no later than the boundary cycle.
- Count arithmetic is BAD_POINT_BIT+1 bits and saturates at BAD_POINT_NUM; it never wraps.
- Reset values: wen_lut=0, waddr_lut=0, wdata_lut=0, active_bank=0, bad_point_num=0, frame_overflow=0, order_err=0, state=IDLE.
- A reset asserted mid-frame discards the partial frame. The checker then sees count 0 until the first full frame commits.

## Structure
- The shared DPC package holds:
  - the LUT word pack/unpack functions (x in [31:16], y in [15:0]);
  - the {y,x} raster-key compare;
  - the FSM state enum.
- One natural sub-module, `frame_edge_detect`: the boundary edge detector with reset-to-1 behaviour, shared with the checker side.

## Test plan
- Frame with flags at (5,2), (9,2), (0,3), then a boundary → three writes: addr {1,0..2}, data 0x0005_0002, 0x0009_0002, 0x0000_0003. After the boundary, active_bank=1 and bad_point_num=3.
- 130 distinct flags in one frame → 128 writes and 2 dropped. At the boundary, bad_point_num=128 and frame_overflow=1.
- Duplicate (7,4) twice, then (3,4) → one write for (7,4). (3,4) is dropped; order_err=1 after commit and bad_point_num=1.
- freeze=1 at a boundary after 4 writes → active_bank and bad_point_num unchanged. The next frame rewrites bank indices from 0.
- Flagged pixel in the boundary cycle, and frame_start held high through reset → the pixel is not written, and no boundary fires until frame_start falls and rises again.
- rst pulsed mid-frame after 10 writes → all outputs return to reset values and the state returns to IDLE. The first later boundary publishes nothing.
